reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 154 +++++++++++++++
 tb/tb_reset_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset release: waits for a stable PLL lock, frees the core,
// then the peripherals, and re-arms on lock loss or a soft request.
module reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       rst_core,
  output logic       rst_periph,
  output logic       sys_ready,
  output logic [7:0] lock_lost_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    WAIT_LOCK    = 3'd0,
    COUNT_STABLE = 3'd1,
    RELEASE_CORE = 3'd2,
    RUN          = 3'd3
  } state_e;

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(STAGE_GAP_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_sync;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  lost_q, lost_d;
  logic        lost_inc;

  logic rst_core_q, rst_core_d;
  logic rst_periph_q, rst_periph_d;
  logic sys_ready_q, sys_ready_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lock_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      lost_q       <= '0;
      rst_core_q   <= 1'b1;
      rst_periph_q <= 1'b1;
      sys_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lost_q       <= lost_d;
      rst_core_q   <= rst_core_d;
      rst_periph_q <= rst_periph_d;
      sys_ready_q  <= sys_ready_d;
    end
  end

  // Lock loss outranks a soft request once the core is out of reset.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lost_inc = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_sync) begin
          state_d = COUNT_STABLE;
        end
      end
      COUNT_STABLE: begin
        if (!lock_sync) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = RELEASE_CORE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RELEASE_CORE: begin
        if (!lock_sync) begin
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          lost_inc = 1'b1;
        end else if (soft_rst_req) begin
          state_d = COUNT_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_sync) begin
          state_d  = WAIT_LOCK;
          lost_inc = 1'b1;
        end else if (soft_rst_req) begin
          state_d = COUNT_STABLE;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the flops switch
  // on the same edge as the state transition.
  always_comb begin
    rst_core_d   = 1'b1;
    rst_periph_d = 1'b1;
    sys_ready_d  = 1'b0;
    unique case (1'b1)
      (state_d == RELEASE_CORE): begin
        rst_core_d = 1'b0;
      end
      (state_d == RUN): begin
        rst_core_d   = 1'b0;
        rst_periph_d = 1'b0;
        sys_ready_d  = 1'b1;
      end
      default: begin
        rst_core_d = 1'b1;
      end
    endcase
    lost_d = lost_q;
    if (lost_inc && lost_q != 8'hFF) begin
      lost_d = lost_q + 8'd1;
    end
  end

  assign rst_core      = rst_core_q;
  assign rst_periph    = rst_periph_q;
  assign sys_ready     = sys_ready_q;
  assign lock_lost_cnt = lost_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed release scenarios plus random
// lock/soft/reset traffic against a release-progress model.
module tb_reset_sequencer;

  localparam int L = 8;
  localparam int G = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       rst_core;
  logic       rst_periph;
  logic       sys_ready;
  logic [7:0] lock_lost_cnt;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  reset_sequencer #(
    .SYNC_STAGES(2),
    .LOCK_STABLE_CYCLES(L),
    .STAGE_GAP_CYCLES(G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_locked(pll_locked),
    .soft_rst_req(soft_rst_req),
    .rst_core(rst_core),
    .rst_periph(rst_periph),
    .sys_ready(sys_ready),
    .lock_lost_cnt(lock_lost_cnt),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (started) begin
      assert (rst_periph || !rst_core)
        else $error("invariant: periph released while core held");
      assert (!sys_ready || (!rst_core && !rst_periph))
        else $error("invariant: ready while a reset is asserted");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: "armed" means lock was seen and a release is in progress;
  // m_cnt counts good edges since the sequence (re)started.
  int m_s0, m_s1, m_armed, m_cnt, m_lost;

  task automatic model_edge(input bit p, input bit s, input bit r);
    int ls;
    if (r) begin
      m_s0 = 0; m_s1 = 0; m_armed = 0; m_cnt = 0; m_lost = 0;
      return;
    end
    ls = m_s1;
    if (!m_armed) begin
      if (ls != 0) begin m_armed = 1; m_cnt = 0; end
    end else if (ls == 0) begin
      if (m_cnt >= L && m_lost < 255) m_lost++;
      m_armed = 0;
      m_cnt = 0;
    end else if (s && m_cnt >= L) begin
      m_cnt = 0;
    end else if (m_cnt < L + G) begin
      m_cnt++;
    end
    m_s1 = m_s0;
    m_s0 = p;
  endtask

  task automatic step(input bit p, input bit s, input bit r);
    int core_e, per_e, st_e;
    pll_locked = p;
    soft_rst_req = s;
    rst = r;
    @(posedge clk);
    model_edge(p, s, r);
    #1;
    started = 1;
    core_e = (m_armed != 0 && m_cnt >= L) ? 0 : 1;
    per_e = (m_armed != 0 && m_cnt >= L + G) ? 0 : 1;
    st_e = (m_armed == 0) ? 0 : (m_cnt >= L + G) ? 3 : (m_cnt >= L) ? 2 : 1;
    chk("rst_core", rst_core, core_e);
    chk("rst_periph", rst_periph, per_e);
    chk("sys_ready", sys_ready, 1 - per_e);
    chk("state_dbg", state_dbg, st_e);
    chk("lost_cnt", lock_lost_cnt, m_lost);
  endtask

  initial begin
    int fc, fp;
    bit p;
    // Power-on lock with no glitches.
    step(0, 0, 1);
    chk("rst_lost", lock_lost_cnt, 0);
    fc = -1; fp = -1;
    for (int e = 0; e < 40; e++) begin
      step(1, 0, 0);
      if (fc < 0 && !rst_core) fc = e;
      if (fp < 0 && !rst_periph) fp = e;
      if (fp >= 0) break;
    end
    chk("core_rel_edge", fc, 10);
    chk("per_rel_edge", fp, 14);
    chk("run_state", state_dbg, 3);

    // One-cycle glitch during stability count.
    step(1, 0, 1);
    fc = -1; fp = -1;
    for (int e = 0; e < 40; e++) begin
      step(e != 6, 0, 0);
      if (fc < 0 && !rst_core) fc = e;
      if (fp < 0 && !rst_periph) fp = e;
      if (fp >= 0) break;
    end
    chk("glitch_core_edge", fc, 17);
    chk("glitch_per_edge", fp, 21);
    chk("glitch_lost", lock_lost_cnt, 0);

    // Lock loss while running, then full re-release.
    fc = -1; fp = -1;
    for (int e = 0; e < 40; e++) begin
      step(e != 0, 0, 0);
      if (e == 1) chk("loss_hold_core", rst_core, 0);
      if (e == 2) begin
        chk("loss_core", rst_core, 1);
        chk("loss_per", rst_periph, 1);
        chk("loss_cnt", lock_lost_cnt, 1);
      end
      if (e > 2 && fc < 0 && !rst_core) fc = e;
      if (e > 2 && fp < 0 && !rst_periph) fp = e;
      if (fp >= 0) break;
    end
    chk("rerel_core_edge", fc, 11);
    chk("rerel_per_edge", fp, 15);

    // Soft request in RUN.
    fc = -1; fp = -1;
    for (int e = 0; e < 40; e++) begin
      step(1, e == 0, 0);
      if (e == 0) begin
        chk("soft_core", rst_core, 1);
        chk("soft_per", rst_periph, 1);
      end
      if (e > 0 && fc < 0 && !rst_core) fc = e;
      if (e > 0 && fp < 0 && !rst_periph) fp = e;
      if (fp >= 0) break;
    end
    chk("soft_core_edge", fc, 8);
    chk("soft_per_edge", fp, 12);
    chk("soft_lost", lock_lost_cnt, 1);

    // Lock loss and soft request seen on the same edge.
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("both_state", state_dbg, 0);
    chk("both_lost", lock_lost_cnt, 2);

    // Saturation of the loss counter.
    for (int i = 0; i < 300; i++) begin
      int k;
      k = 0;
      while (rst_core && k < 40) begin
        step(1, 0, 0);
        k++;
      end
      if (rst_core) begin
        chk("sat_release", rst_core, 0);
        break;
      end
      repeat (3) step(0, 0, 0);
    end
    chk("sat_lost", lock_lost_cnt, 255);
    step(1, 0, 1);
    chk("sat_clear", lock_lost_cnt, 0);

    // Random traffic.
    p = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 14) == 0) p = !p;
      step(p, $urandom_range(0, 19) == 0, $urandom_range(0, 599) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
